// File: rtl/magic_nor_sequencer.sv
// Sequencer that fetches NOR/INV gate instructions and issues them to a memristive crossbar.
// Optional build macro MAGIC_OP_COUNT_EN enables the saturating op_count handshake counter.
module magic_nor_sequencer #(
    parameter int CELL_W = 6,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    prog_we,
    input  logic [ADDR_W-1:0]       prog_addr,
    input  logic [2+3*CELL_W-1:0]   prog_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic                    xbar_valid,
    input  logic                    xbar_ready,
    output logic [1:0]              xbar_op,
    output logic [1:0]              xbar_in_cnt,
    output logic [CELL_W-1:0]       xbar_a,
    output logic [CELL_W-1:0]       xbar_b,
    output logic [CELL_W-1:0]       xbar_y,
    output logic [15:0]             op_count
);

    localparam int IW = 2 + 3 * CELL_W;
    localparam logic [1:0] OP_END = 2'b00;
    localparam logic [1:0] OP_INV = 2'b01;
    localparam logic [1:0] OP_NOR = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;
    localparam logic [1:0] XOP_INIT = 2'b01;
    localparam logic [1:0] XOP_EVAL = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_INIT  = 3'd2,
        S_EVAL  = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    function automatic logic [1:0] eval_in_cnt(input logic [1:0] op);
        case (op)
            OP_INV:  eval_in_cnt = 2'd1;
            OP_NOR:  eval_in_cnt = 2'd2;
            default: eval_in_cnt = 2'd0;
        endcase
    endfunction

    logic [IW-1:0]      r_mem [DEPTH];
    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic [IW-1:0]      r_instr;
    logic [IW-1:0]      w_instr_nxt;
    logic [IW-1:0]      w_fetch_word;
    logic               r_err;
    logic               w_err_nxt;
    logic               r_busy;
    logic               r_done;
    logic               r_xbar_valid;
    logic [1:0]         r_xbar_op;
    logic [1:0]         r_xbar_in_cnt;
    logic [CELL_W-1:0]  r_xbar_a;
    logic [CELL_W-1:0]  r_xbar_b;
    logic [CELL_W-1:0]  r_xbar_y;
    logic               w_xbar_valid;
    logic [1:0]         w_xbar_op;
    logic [1:0]         w_xbar_in_cnt;
    logic [CELL_W-1:0]  w_xbar_a;
    logic [CELL_W-1:0]  w_xbar_b;
    logic [CELL_W-1:0]  w_xbar_y;
    logic               w_hs;
    logic               w_start_acc;
    logic [1:0]         w_iop;

    assign w_hs         = r_xbar_valid & xbar_ready;
    assign w_start_acc  = (r_state == S_IDLE) & start;
    assign w_fetch_word = r_mem[r_pc];
    assign w_iop        = w_instr_nxt[IW-1 -: 2];

    // Program memory: written only while idle, never reset.
    always_ff @(posedge clk) begin
        if (prog_we && !r_busy) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    // Next-state, program counter, instruction latch and error flag.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        w_err_nxt   = r_err;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_pc_nxt    = {ADDR_W{1'b0}};
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_FETCH;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FETCH: begin
                w_instr_nxt = w_fetch_word;
                case (w_fetch_word[IW-1 -: 2])
                    OP_END:  w_state_nxt = S_DONE;
                    OP_RSV: begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_ERROR;
                    end
                    default: w_state_nxt = S_INIT;
                endcase
            end
            S_INIT: begin
                if (w_hs) begin
                    w_state_nxt = S_EVAL;
                end else begin
                    w_state_nxt = S_INIT;
                end
            end
            S_EVAL: begin
                if (!w_hs) begin
                    w_state_nxt = S_EVAL;
                end else if (r_pc == ADDR_W'(DEPTH - 1)) begin
                    // Last address behaves as an implicit END; pc never wraps.
                    w_state_nxt = S_DONE;
                end else begin
                    w_pc_nxt    = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
                    w_state_nxt = S_FETCH;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERROR: w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Crossbar outputs decoded from the upcoming state so they leave the flops glitch-free.
    always_comb begin
        w_xbar_valid  = 1'b0;
        w_xbar_op     = 2'b00;
        w_xbar_in_cnt = 2'd0;
        w_xbar_a      = {CELL_W{1'b0}};
        w_xbar_b      = {CELL_W{1'b0}};
        w_xbar_y      = {CELL_W{1'b0}};
        case (w_state_nxt)
            S_INIT: begin
                w_xbar_valid = 1'b1;
                w_xbar_op    = XOP_INIT;
                w_xbar_y     = w_instr_nxt[CELL_W-1:0];
            end
            S_EVAL: begin
                w_xbar_valid  = 1'b1;
                w_xbar_op     = XOP_EVAL;
                w_xbar_in_cnt = eval_in_cnt(w_iop);
                w_xbar_a      = w_instr_nxt[3*CELL_W-1 -: CELL_W];
                w_xbar_y      = w_instr_nxt[CELL_W-1:0];
                if (w_iop == OP_NOR) begin
                    w_xbar_b = w_instr_nxt[2*CELL_W-1 -: CELL_W];
                end else begin
                    w_xbar_b = {CELL_W{1'b0}};
                end
            end
            default: begin
                w_xbar_valid = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= {ADDR_W{1'b0}};
            r_instr       <= {IW{1'b0}};
            r_err         <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_xbar_valid  <= 1'b0;
            r_xbar_op     <= 2'b00;
            r_xbar_in_cnt <= 2'd0;
            r_xbar_a      <= {CELL_W{1'b0}};
            r_xbar_b      <= {CELL_W{1'b0}};
            r_xbar_y      <= {CELL_W{1'b0}};
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_instr       <= w_instr_nxt;
            r_err         <= w_err_nxt;
            r_busy        <= (w_state_nxt != S_IDLE);
            r_done        <= (w_state_nxt == S_DONE);
            r_xbar_valid  <= w_xbar_valid;
            r_xbar_op     <= w_xbar_op;
            r_xbar_in_cnt <= w_xbar_in_cnt;
            r_xbar_a      <= w_xbar_a;
            r_xbar_b      <= w_xbar_b;
            r_xbar_y      <= w_xbar_y;
        end
    end

`ifdef MAGIC_OP_COUNT_EN
    logic [15:0] r_op_count;

    // Saturating count of accepted crossbar operations since the last start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_count <= 16'd0;
        end else if (w_start_acc) begin
            r_op_count <= 16'd0;
        end else if (w_hs && (r_op_count != 16'hFFFF)) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;
`else
    logic w_unused_start_acc;
    assign w_unused_start_acc = w_start_acc;
    assign op_count = 16'd0;
`endif

    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign xbar_valid  = r_xbar_valid;
    assign xbar_op     = r_xbar_op;
    assign xbar_in_cnt = r_xbar_in_cnt;
    assign xbar_a      = r_xbar_a;
    assign xbar_b      = r_xbar_b;
    assign xbar_y      = r_xbar_y;

endmodule

// File: tb/tb_magic_nor_sequencer.sv
// Directed bench for magic_nor_sequencer: hand-computed crossbar sequences and done latencies.
module tb_magic_nor_sequencer;

    logic        clk;
    logic        rst_n;
    logic        prog_we;
    logic [4:0]  prog_addr;
    logic [19:0] prog_data;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic        xbar_valid;
    logic        xbar_ready;
    logic [1:0]  xbar_op;
    logic [1:0]  xbar_in_cnt;
    logic [5:0]  xbar_a;
    logic [5:0]  xbar_b;
    logic [5:0]  xbar_y;
    logic [15:0] op_count;

    int n_total;
    int n_bad;
    int cyc;
    int exp_oc4;
    int exp_oc64;

    magic_nor_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .xbar_valid  (xbar_valid),
        .xbar_ready  (xbar_ready),
        .xbar_op     (xbar_op),
        .xbar_in_cnt (xbar_in_cnt),
        .xbar_a      (xbar_a),
        .xbar_b      (xbar_b),
        .xbar_y      (xbar_y),
        .op_count    (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [19:0] enc(input logic [1:0] op, input logic [5:0] a,
                                        input logic [5:0] b, input logic [5:0] y);
        enc = {op, a, b, y};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [4:0] ad, input logic [19:0] d);
        prog_we   = 1'b1;
        prog_addr = ad;
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    task automatic go();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int c);
        c = c0;
        while (done !== 1'b1 && c < 300) begin
            tick();
            c++;
        end
    endtask

    task automatic chk_x(input string tag, input logic v, input logic [1:0] op,
                         input logic [1:0] cnt, input logic [5:0] a, input logic [5:0] b,
                         input logic [5:0] y);
        chk({tag, ".valid"}, xbar_valid, v);
        chk({tag, ".op"}, xbar_op, op);
        chk({tag, ".cnt"}, xbar_in_cnt, cnt);
        chk({tag, ".a"}, xbar_a, a);
        chk({tag, ".b"}, xbar_b, b);
        chk({tag, ".y"}, xbar_y, y);
    endtask

    initial begin
        n_total    = 0;
        n_bad      = 0;
`ifdef MAGIC_OP_COUNT_EN
        exp_oc4    = 4;
        exp_oc64   = 64;
`else
        exp_oc4    = 0;
        exp_oc64   = 0;
`endif
        rst_n      = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = 5'd0;
        prog_data  = 20'd0;
        start      = 1'b0;
        xbar_ready = 1'b1;
        tick();
        tick();
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.err", err, 1'b0);
        chk("rst.opcnt", op_count, 16'd0);
        chk_x("rst", 1'b0, 2'b00, 2'd0, 6'd0, 6'd0, 6'd0);
        rst_n = 1'b1;
        tick();

        // Basic program: NOR2(1,2)->10, INV(10)->11, END; INV carries a nonzero b that must not appear.
        wr(5'd0, enc(2'b10, 6'd1, 6'd2, 6'd10));
        wr(5'd1, enc(2'b01, 6'd10, 6'd5, 6'd11));
        wr(5'd2, enc(2'b00, 6'd0, 6'd0, 6'd0));
        go();
        chk("p1.fetch.busy", busy, 1'b1);
        chk_x("p1.fetch", 1'b0, 2'b00, 2'd0, 6'd0, 6'd0, 6'd0);
        tick();
        chk_x("p1.init10", 1'b1, 2'b01, 2'd0, 6'd0, 6'd0, 6'd10);
        tick();
        chk_x("p1.eval10", 1'b1, 2'b10, 2'd2, 6'd1, 6'd2, 6'd10);
        tick();
        chk("p1.fetch2.valid", xbar_valid, 1'b0);
        tick();
        chk_x("p1.init11", 1'b1, 2'b01, 2'd0, 6'd0, 6'd0, 6'd11);
        tick();
        chk_x("p1.eval11", 1'b1, 2'b10, 2'd1, 6'd10, 6'd0, 6'd11);
        tick();
        chk("p1.c6.done", done, 1'b0);
        tick();
        chk("p1.c7.done", done, 1'b1);
        chk("p1.opcnt", op_count, exp_oc4[15:0]);
        tick();
        chk("p1.c8.done", done, 1'b0);
        chk("p1.c8.busy", busy, 1'b0);

        // Backpressure: ready low for three cycles in the first INIT.
        xbar_ready = 1'b0;
        go();
        tick();
        chk_x("bp.init.c1", 1'b1, 2'b01, 2'd0, 6'd0, 6'd0, 6'd10);
        tick();
        chk_x("bp.init.c2", 1'b1, 2'b01, 2'd0, 6'd0, 6'd0, 6'd10);
        tick();
        chk_x("bp.init.c3", 1'b1, 2'b01, 2'd0, 6'd0, 6'd0, 6'd10);
        tick();
        chk_x("bp.init.c4", 1'b1, 2'b01, 2'd0, 6'd0, 6'd0, 6'd10);
        xbar_ready = 1'b1;
        tick();
        chk_x("bp.eval10", 1'b1, 2'b10, 2'd2, 6'd1, 6'd2, 6'd10);
        tick();
        tick();
        chk_x("bp.init11", 1'b1, 2'b01, 2'd0, 6'd0, 6'd0, 6'd11);
        tick();
        chk_x("bp.eval11", 1'b1, 2'b10, 2'd1, 6'd10, 6'd0, 6'd11);
        wait_done(8, cyc);
        chk("bp.latency", cyc, 10);
        chk("bp.opcnt", op_count, exp_oc4[15:0]);
        tick();

        // Reserved opcode at address 0.
        wr(5'd0, enc(2'b11, 6'd1, 6'd2, 6'd3));
        go();
        tick();
        chk("er.c1.err", err, 1'b1);
        chk("er.c1.done", done, 1'b0);
        chk("er.c1.valid", xbar_valid, 1'b0);
        tick();
        chk("er.c2.done", done, 1'b1);
        chk("er.c2.valid", xbar_valid, 1'b0);
        tick();
        chk("er.c3.done", done, 1'b0);
        chk("er.c3.busy", busy, 1'b0);
        chk("er.sticky", err, 1'b1);
        wr(5'd0, enc(2'b10, 6'd1, 6'd2, 6'd10));
        chk("er.idle.err", err, 1'b1);

        // Writes and start while busy are ignored; the next start clears err.
        go();
        chk("wb.err.clr", err, 1'b0);
        prog_we   = 1'b1;
        prog_addr = 5'd0;
        prog_data = enc(2'b01, 6'd7, 6'd0, 6'd9);
        start     = 1'b1;
        tick();
        prog_we   = 1'b0;
        start     = 1'b0;
        chk_x("wb.init10", 1'b1, 2'b01, 2'd0, 6'd0, 6'd0, 6'd10);
        wait_done(1, cyc);
        chk("wb.latency", cyc, 7);
        tick();
        chk("wb.idle.busy", busy, 1'b0);
        go();
        tick();
        chk_x("wb.rerun.init", 1'b1, 2'b01, 2'd0, 6'd0, 6'd0, 6'd10);
        tick();
        chk_x("wb.rerun.eval", 1'b1, 2'b10, 2'd2, 6'd1, 6'd2, 6'd10);
        wait_done(2, cyc);
        chk("wb.rerun.latency", cyc, 7);
        tick();

        // Asynchronous reset during EVAL aborts with no done pulse.
        go();
        tick();
        tick();
        chk("rs.in.eval", xbar_op, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("rs.valid", xbar_valid, 1'b0);
        chk("rs.busy", busy, 1'b0);
        chk("rs.op", xbar_op, 2'b00);
        tick();
        chk("rs.done", done, 1'b0);
        chk("rs.opcnt", op_count, 16'd0);
        rst_n = 1'b1;
        tick();
        chk("rs.idle.done", done, 1'b0);
        go();
        tick();
        tick();
        chk_x("rs.rerun.eval", 1'b1, 2'b10, 2'd2, 6'd1, 6'd2, 6'd10);
        wait_done(2, cyc);
        chk("rs.rerun.latency", cyc, 7);
        tick();

        // Full memory of NOR2 gates with no END: terminates after address 31.
        for (int i = 0; i < 32; i++) begin
            wr(5'(i), enc(2'b10, 6'd3, 6'd4, 6'(i + 20)));
        end
        go();
        wait_done(0, cyc);
        chk("full.latency", cyc, 96);
        chk("full.opcnt", op_count, exp_oc64[15:0]);
        tick();
        chk("full.after.done", done, 1'b0);
        chk("full.after.busy", busy, 1'b0);
        chk("full.after.valid", xbar_valid, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
